// File: rtl/apb_memory_slave.sv
// APB slave backed by a byte-lane-writable word memory, with a fixed number of
// wait states per access phase. PSLVERR is tied low.
module apb_memory_slave #(
  parameter int unsigned SIZE_IN_BYTES = 1024,
  parameter int unsigned DELAY         = 0
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic [31:0] PADDR,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic [2:0]  PPROT,
  input  logic [3:0]  PSTRB
);

  localparam int unsigned Words    = SIZE_IN_BYTES / 4;
  localparam int unsigned IdxW     = (Words > 1) ? $clog2(Words) : 1;
  localparam logic [7:0]  DelayCnt = 8'(DELAY);

  typedef enum logic [1:0] {StIdle, StWait, StAccess} state_e;

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [31:0]     prdata_q, prdata_d;
  logic            we;
  logic [IdxW-1:0] idx;
  logic [31:0]     rd_word;
  logic [31:0]     load_word;
  logic [31:0]     mem [Words];
  logic            unused_bits;

  // Upper address bits are dropped so accesses wrap modulo the memory size.
  assign idx         = IdxW'((PADDR >> 2) & 32'(Words - 1));
  assign rd_word     = mem[idx];
  assign load_word   = PWRITE ? 32'h0 : rd_word;
  assign unused_bits = ^{PPROT, PADDR};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prdata_d = prdata_q;
    we       = 1'b0;
    if (!PSEL) begin
      state_d  = StIdle;
      cnt_d    = 8'd0;
      prdata_d = 32'h0;
    end else if (!PENABLE || state_q == StIdle) begin
      // Setup phase, or an access phase that arrived without one.
      if (PENABLE && DELAY == 0) begin
        we       = PWRITE;
        prdata_d = 32'h0;
        state_d  = StIdle;
      end else begin
        prdata_d = load_word;
        if (DELAY == 0) begin
          state_d = StAccess;
        end else begin
          state_d = StWait;
          cnt_d   = DelayCnt;
        end
      end
    end else if (state_q == StWait) begin
      if (cnt_q > 8'd1) begin
        cnt_d = cnt_q - 8'd1;
      end else begin
        cnt_d    = 8'd0;
        state_d  = StAccess;
        prdata_d = load_word;
      end
    end else begin
      // Completing edge of the access phase.
      we       = PWRITE;
      prdata_d = 32'h0;
      state_d  = StIdle;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= StIdle;
      cnt_q    <= 8'd0;
      prdata_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prdata_q <= prdata_d;
    end
  end

  // Storage is deliberately not reset; writes are suppressed while reset is held.
  always_ff @(posedge PCLK) begin
    if (we && !PRESET) begin
      for (int i = 0; i < 4; i++) begin
        if (PSTRB[i]) mem[idx][8*i +: 8] <= PWDATA[8*i +: 8];
      end
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = (state_q != StWait);
  assign PSLVERR = 1'b0;

endmodule

// File: tb/tb_apb_memory_slave.sv
// Directed bench: three slaves on one bus (DELAY 0, 2, 3), each with its own PSEL.
module tb_apb_memory_slave;

  logic        pclk;
  logic        preset;
  logic [2:0]  psel;
  logic [31:0] paddr;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [2:0]  pprot;
  logic [3:0]  pstrb;
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];

  int n_chk;
  int n_fail;

  apb_memory_slave #(.SIZE_IN_BYTES(1024), .DELAY(0)) u_d0 (
    .PCLK(pclk), .PRESET(preset), .PSEL(psel[0]), .PADDR(paddr), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]), .PPROT(pprot), .PSTRB(pstrb)
  );

  apb_memory_slave #(.SIZE_IN_BYTES(1024), .DELAY(2)) u_d2 (
    .PCLK(pclk), .PRESET(preset), .PSEL(psel[1]), .PADDR(paddr), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]), .PPROT(pprot), .PSTRB(pstrb)
  );

  apb_memory_slave #(.SIZE_IN_BYTES(1024), .DELAY(3)) u_d3 (
    .PCLK(pclk), .PRESET(preset), .PSEL(psel[2]), .PADDR(paddr), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata[2]), .PREADY(pready[2]),
    .PSLVERR(pslverr[2]), .PPROT(pprot), .PSTRB(pstrb)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Starts just after a rising edge; returns just after the completing edge.
  task automatic apb_xfer(input int s, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          output logic [31:0] rdata, output int waits);
    psel    = 3'(1 << s);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    pstrb   = strb;
    @(posedge pclk);
    #1 penable = 1'b1;
    waits = 0;
    @(negedge pclk);
    while (!pready[s] && waits < 300) begin
      waits++;
      @(negedge pclk);
    end
    if (!pready[s]) chk_eq("pready_timeout", 32'(pready[s]), 32'd1);
    rdata = prdata[s];
    @(posedge pclk);
    #1;
    psel    = 3'b000;
    penable = 1'b0;
  endtask

  task automatic apb_wr(input int s, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb);
    logic [31:0] dummy;
    int          w;
    apb_xfer(s, 1'b1, addr, data, strb, dummy, w);
  endtask

  task automatic apb_rd(input int s, input logic [31:0] addr, output logic [31:0] data,
                        output int waits);
    apb_xfer(s, 1'b0, addr, 32'h0, 4'h0, data, waits);
  endtask

  initial begin
    logic [31:0] rd;
    int          w;
    n_chk   = 0;
    n_fail  = 0;
    preset  = 1'b1;
    psel    = 3'b000;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 32'h0;
    pwdata  = 32'h0;
    pprot   = 3'b000;
    pstrb   = 4'h0;

    #2;
    for (int i = 0; i < 3; i++) begin
      chk_eq("reset_pready", 32'(pready[i]), 32'd1);
      chk_eq("reset_prdata", prdata[i], 32'h0);
      chk_eq("reset_pslverr", 32'(pslverr[i]), 32'd0);
    end
    @(posedge pclk);
    #1 preset = 1'b0;

    // Basic write/read, no wait states.
    apb_wr(0, 32'h010, 32'hDEADBEEF, 4'hF);
    apb_rd(0, 32'h010, rd, w);
    chk_eq("basic_rdata", rd, 32'hDEADBEEF);
    chk_eq("basic_waits", 32'(w), 32'd0);
    chk_eq("basic_pslverr", 32'(pslverr[0]), 32'd0);
    @(negedge pclk);
    chk_eq("prdata_idle_zero", prdata[0], 32'h0);
    @(posedge pclk);
    #1;

    // Byte strobes.
    apb_wr(0, 32'h020, 32'h11223344, 4'hF);
    apb_wr(0, 32'h020, 32'hAABBCCDD, 4'b0101);
    apb_rd(0, 32'h020, rd, w);
    chk_eq("strb_0101", rd, 32'h11BB33DD);
    apb_wr(0, 32'h020, 32'hFFFFFFFF, 4'h0);
    apb_rd(0, 32'h020, rd, w);
    chk_eq("strb_none", rd, 32'h11BB33DD);
    apb_wr(0, 32'h020, 32'h99000000, 4'b1000);
    apb_rd(0, 32'h020, rd, w);
    chk_eq("strb_1000", rd, 32'h99BB33DD);

    // Address wrap and ignored low address bits.
    apb_wr(0, 32'h404, 32'h5A5A5A5A, 4'hF);
    apb_rd(0, 32'h004, rd, w);
    chk_eq("wrap_004", rd, 32'h5A5A5A5A);
    apb_rd(0, 32'h007, rd, w);
    chk_eq("wrap_007", rd, 32'h5A5A5A5A);

    // Wait states with DELAY=3.
    apb_wr(2, 32'h040, 32'hCAFEF00D, 4'hF);
    apb_rd(2, 32'h040, rd, w);
    chk_eq("d3_read_waits", 32'(w), 32'd3);
    chk_eq("d3_read_rdata", rd, 32'hCAFEF00D);
    apb_wr(2, 32'h100, 32'h12345678, 4'hF);

    // Reset asserted during a write's wait states.
    psel    = 3'b100;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h100;
    pwdata  = 32'hFFFFFFFF;
    pstrb   = 4'hF;
    @(posedge pclk);
    #1 penable = 1'b1;
    @(negedge pclk);
    chk_eq("d3_wait_pready", 32'(pready[2]), 32'd0);
    #1 preset = 1'b1;
    #1;
    chk_eq("midreset_pready", 32'(pready[2]), 32'd1);
    chk_eq("midreset_prdata", prdata[2], 32'h0);
    @(posedge pclk);
    @(posedge pclk);
    #1;
    preset  = 1'b0;
    psel    = 3'b000;
    penable = 1'b0;
    @(posedge pclk);
    #1;
    apb_rd(2, 32'h100, rd, w);
    chk_eq("midreset_keep", rd, 32'h12345678);

    // Bus activity with no PSEL must not touch memory.
    psel    = 3'b000;
    penable = 1'b1;
    pwrite  = 1'b1;
    paddr   = 32'h100;
    pwdata  = 32'h0;
    pstrb   = 4'hF;
    repeat (4) @(posedge pclk);
    #1 penable = 1'b0;
    apb_rd(2, 32'h100, rd, w);
    chk_eq("nosel_keep_d3", rd, 32'h12345678);
    apb_wr(1, 32'h010, 32'h00000000, 4'hF);
    apb_rd(0, 32'h010, rd, w);
    chk_eq("othersel_keep_d0", rd, 32'hDEADBEEF);

    // Back-to-back sweeps on DELAY=0 and DELAY=2 slaves.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 256; i++) apb_wr(s, 32'(i * 4), 32'(i * 4), 4'hF);
      for (int i = 0; i < 256; i++) begin
        apb_rd(s, 32'(i * 4), rd, w);
        chk_eq(s == 0 ? "sweep_d0" : "sweep_d2", rd, 32'(i * 4));
        if (i == 0) chk_eq("sweep_waits", 32'(w), s == 0 ? 32'd0 : 32'd2);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_memory_slave.md
Name: apb_memory_slave

Overview:
- APB (AMBA3/AMBA4) slave wrapping a byte-addressable word memory of SIZE_IN_BYTES.
- Sits behind an APB master/decoder; one instance per PSEL line.
- Supports a programmable number of wait states via PREADY, and byte-lane writes via PSTRB.
- PSLVERR is never asserted.

Parameters:
- SIZE_IN_BYTES, 1024: memory size in bytes. Power of two, >= 4. Word count = SIZE_IN_BYTES/4.
- DELAY, 0: number of wait-state cycles (PREADY low) inserted in every access phase. Range 0..255.

Ports:
- PCLK  input  1  APB clock; all state updates on rising edge.
- PRESET  input  1  asynchronous, active-high reset.
- PSEL  input  1  slave select.
- PADDR  input  32  byte address; only bits [log2(SIZE_IN_BYTES)-1:2] are used.
- PENABLE  input  1  access-phase indicator.
- PWRITE  input  1  1=write, 0=read.
- PWDATA  input  32  write data.
- PRDATA  output  32  read data.
- PREADY  output  1  transfer completion / wait-state control.
- PSLVERR  output  1  error response; constant 0.
- PPROT  input  3  protection attributes; accepted and ignored.
- PSTRB  input  4  write byte strobes; PSTRB[i] enables PWDATA[8i+7:8i].

Behaviour:
- Reset (PRESET=1, asynchronous): PRDATA=0, PREADY=1, PSLVERR=0, wait counter=0.
  - Memory contents are not reset; undefined until written.
- Phases:
  - Setup phase: PSEL=1, PENABLE=0.
  - Access phase: PSEL=1, PENABLE=1.
  - Transfer completes on the rising edge where PSEL & PENABLE & PREADY.
- Word index = PADDR[log2(SIZE_IN_BYTES)-1:2].
  - Upper address bits are ignored, so addresses wrap modulo SIZE_IN_BYTES.
  - PADDR[1:0] is ignored.
- Wait states:
  - At the setup-phase edge: if DELAY=0, PREADY stays 1. Otherwise PREADY is set to 0 and the counter loads DELAY.
  - Each access-phase edge with the counter > 1 decrements it.
  - When the counter reaches 1, PREADY returns to 1 on the next edge.
  - Net effect: exactly DELAY access cycles with PREADY=0, followed by one cycle with PREADY=1.
  - PREADY=1 whenever no transfer is in progress.
- Read:
  - PRDATA is registered from mem[index] so it is valid in every access-phase cycle where PREADY=1. It is loaded at the setup edge and reloaded on the final wait edge.
  - After completion PRDATA returns to 0 on the next edge unless a new read is in progress.
- Write:
  - Committed at the completing edge only (PSEL & PENABLE & PREADY & PWRITE).
  - Only lanes with PSTRB[i]=1 are updated. PSTRB=4'h0 leaves memory unchanged.
  - Writes never alter PRDATA.
- PSEL=0: no memory access, PREADY=1, counter held at 0, PRDATA=0.
- Back-to-back transfers: a setup phase may immediately follow a completing access phase. Wait-state insertion restarts for each transfer.
- Protocol violation (PENABLE=1 without a preceding setup phase): treated as an access phase with DELAY wait states counted from that cycle.
- Reset mid-transfer: the pending write is discarded and outputs go to reset values. The master must restart the transfer.
- A read of an address in the same transfer sequence after a completed write returns the new data (write-then-read coherency).

Test Plan:
- Basic write/read (DELAY=0): write 0xDEADBEEF to 0x010, read 0x010 -> PRDATA=0xDEADBEEF in the access cycle, PREADY=1 throughout, PSLVERR=0.
- Byte strobes: write 0x11223344 to 0x020 with PSTRB=4'hF, then write 0xAABBCCDD with PSTRB=4'b0101 -> read returns 0x11BB33DD. A write with PSTRB=0 leaves the word unchanged.
- Address wrap (SIZE_IN_BYTES=1024): write 0x5A5A5A5A to 0x404 -> read of 0x004 returns 0x5A5A5A5A. Read of 0x007 returns the same word.
- Wait states (DELAY=3): a single read shows PREADY=0 for exactly 3 access cycles, then 1 for one cycle with valid PRDATA. A write is committed only at that edge.
- Back-to-back sweep: write 256 words with data=address to 0x000..0x3FC, read all back, all match. Repeat with DELAY=0 and DELAY=2.
- Reset/isolation:
  - Assert PRESET during a DELAY=3 write's wait states -> PREADY=1, PRDATA=0 immediately, and the target word keeps its old value.
  - Transfers with PSEL=0 do not modify memory.
